extended_div_core: RTL and testbench

- Sequential 24-bit mantissa divider for the single-precision FP division path.
- Computes ans = floor(Q·2^23 / M): the quotient of two 24-bit significands (hidden bit at bit 23) as a fixed-point value with 1 integer bit and 23 fraction bits.
- Sits between exponent/sign handling and the normalise/round stage. That stage uses ans[23] to decide whether to normalise, and uses sticky for rounding.

---
 rtl/extended_div_core_if.sv | 24 ++
 rtl/extended_div_core.sv | 108 ++++++++++
 tb/tb_extended_div_core.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/extended_div_core_if.sv
// Request/result bundle for the sequential significand divider.
interface extended_div_core_if #(
    parameter int unsigned W = 24
);
    logic         start;
    logic [W-1:0] Q;
    logic [W-1:0] M;
    logic         busy;
    logic         done;
    logic [W-1:0] ans;
    logic         sticky;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, Q, M,
        input  busy, done, ans, sticky, div_by_zero, overflow
    );

    modport slave (
        input  start, Q, M,
        output busy, done, ans, sticky, div_by_zero, overflow
    );
endinterface

// File: rtl/extended_div_core.sv
// Restoring divider: ans = floor(Q * 2^(W-1) / M), one quotient bit per clock, MSB first.
module extended_div_core #(
    parameter int unsigned W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    extended_div_core_if.slave   bus
);
    localparam int unsigned CW = $clog2(W + 1);

    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [W-1:0]  ans_q,    ans_d;
    logic          sticky_q, sticky_d;
    logic          dbz_q,    dbz_d;
    logic          ovf_q,    ovf_d;
    logic [W-1:0]  m_q,      m_d;
    logic [W:0]    r_q,      r_d;
    logic [W-1:0]  quo_q,    quo_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic          ge;
    logic [W:0]    r_next;
    logic [W:0]    r_shift;
    logic [W-1:0]  quo_next;

    always_comb begin
        ge       = (r_q >= {1'b0, m_q});
        r_next   = ge ? (r_q - {1'b0, m_q}) : r_q;
        r_shift  = r_next << 1;
        quo_next = {quo_q[W-2:0], ge};

        busy_d   = busy_q;
        done_d   = 1'b0;
        ans_d    = ans_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        m_d      = m_q;
        r_d      = r_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;

        if (!busy_q) begin
            if (bus.start) begin
                busy_d = 1'b1;
                m_d    = bus.M;
                r_d    = {1'b0, bus.Q};
                quo_d  = '0;
                cnt_d  = CW'(W);
                dbz_d  = (bus.M == '0);
                ovf_d  = (bus.M != '0) && ({1'b0, bus.Q} >= {bus.M, 1'b0});
            end
        end else begin
            r_d   = r_shift;
            quo_d = quo_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                // Special cases still run the full iteration count; only the result is overridden.
                if (dbz_q) begin
                    ans_d    = '1;
                    sticky_d = 1'b0;
                end else if (ovf_q) begin
                    ans_d    = '1;
                    sticky_d = 1'b1;
                end else begin
                    ans_d    = quo_next;
                    sticky_d = (r_shift != '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ans_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            m_q      <= '0;
            r_q      <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            ans_q    <= ans_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            m_q      <= m_d;
            r_q      <= r_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ans         = ans_q;
    assign bus.sticky      = sticky_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_extended_div_core.sv
// Directed-vector bench for extended_div_core with hand-computed quotients.
module tb_extended_div_core;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    extended_div_core_if #(.W(24)) bus ();

    extended_div_core #(.W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_op(input logic [23:0] q, input logic [23:0] m, output int n);
        @(negedge clk);
        bus.Q = q;
        bus.M = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.Q = 24'h0;
        bus.M = 24'h0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.busy, bus.done, bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== 29'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b ans=%h sticky=%b dbz=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end
    endtask

    task automatic test_normal;
        int n;
        run_op(24'hFE1000, 24'h878000, n);
        checks++;
        if (n !== 24) begin errors++; $display("FAIL latency got %0d want 24", n); end
        checks++;
        if ({bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== {24'hF00000, 3'b000}) begin
            errors++;
            $display("FAIL exact_1p875 got ans=%h sticky=%b dbz=%b ovf=%b want F00000 0 0 0",
                     bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.ans} !== {1'b0, 24'hF00000}) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b ans=%h want 0 F00000", bus.done, bus.ans);
        end

        run_op(24'h800000, 24'hC00000, n);
        checks++;
        if ({bus.ans, bus.sticky} !== {24'h555555, 1'b1}) begin
            errors++;
            $display("FAIL two_thirds got ans=%h sticky=%b want 555555 1", bus.ans, bus.sticky);
        end

        run_op(24'hFFFFFF, 24'hFFFFFF, n);
        checks++;
        if ({bus.ans, bus.sticky} !== {24'h800000, 1'b0}) begin
            errors++;
            $display("FAIL equal_ops got ans=%h sticky=%b want 800000 0", bus.ans, bus.sticky);
        end

        // M = 2^23 makes the quotient exactly Q.
        run_op(24'hFFFFFF, 24'h800000, n);
        checks++;
        if ({bus.ans, bus.sticky, bus.overflow} !== {24'hFFFFFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL max_quot got ans=%h sticky=%b ovf=%b want FFFFFF 0 0",
                     bus.ans, bus.sticky, bus.overflow);
        end
    endtask

    task automatic test_special;
        int n;
        run_op(24'h123456, 24'h000000, n);
        checks++;
        if (n !== 24) begin errors++; $display("FAIL dbz_latency got %0d want 24", n); end
        checks++;
        if ({bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== {24'hFFFFFF, 3'b010}) begin
            errors++;
            $display("FAIL div_by_zero got ans=%h sticky=%b dbz=%b ovf=%b want FFFFFF 0 1 0",
                     bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end

        run_op(24'h000010, 24'h000004, n);
        checks++;
        if ({bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== {24'hFFFFFF, 3'b101}) begin
            errors++;
            $display("FAIL overflow got ans=%h sticky=%b dbz=%b ovf=%b want FFFFFF 1 0 1",
                     bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end

        run_op(24'h000000, 24'h800000, n);
        checks++;
        if ({bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== {24'h000000, 3'b000}) begin
            errors++;
            $display("FAIL zero_dividend got ans=%h sticky=%b dbz=%b ovf=%b want 000000 0 0 0",
                     bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end
    endtask

    task automatic test_ignore_busy;
        int n;
        @(negedge clk);
        bus.Q = 24'hFE1000; bus.M = 24'h878000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        repeat (5) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        bus.Q = 24'h000010; bus.M = 24'h000004; bus.start = 1'b1;
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
        while (n < 40 && !bus.done) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 24) begin errors++; $display("FAIL ignore_latency got %0d want 24", n); end
        checks++;
        if ({bus.ans, bus.sticky, bus.overflow} !== {24'hF00000, 2'b00}) begin
            errors++;
            $display("FAIL ignore_busy got ans=%h sticky=%b ovf=%b want F00000 0 0",
                     bus.ans, bus.sticky, bus.overflow);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        bus.Q = 24'h800000; bus.M = 24'hC00000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (23) @(posedge clk);
        @(negedge clk);
        bus.Q = 24'hFE1000; bus.M = 24'h878000; bus.start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.busy, bus.ans} !== {2'b10, 24'h555555}) begin
            errors++;
            $display("FAIL start_on_done got done=%b busy=%b ans=%h want 1 0 555555",
                     bus.done, bus.busy, bus.ans);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b want 1", bus.busy);
        end
        n = 0;
        while (n < 40) begin @(posedge clk); #1; n++; if (bus.done) break; end
        checks++;
        if ({n[7:0], bus.ans, bus.sticky} !== {8'd24, 24'hF00000, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got n=%0d ans=%h sticky=%b want 24 F00000 0",
                     n, bus.ans, bus.sticky);
        end
    endtask

    task automatic test_reset_abort;
        int n;
        int seen;
        @(negedge clk);
        bus.Q = 24'hFE1000; bus.M = 24'h878000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.ans, bus.sticky, bus.div_by_zero, bus.overflow} !== 29'h0) begin
            errors++;
            $display("FAIL reset_abort got busy=%b done=%b ans=%h sticky=%b dbz=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.ans, bus.sticky, bus.div_by_zero, bus.overflow);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.done) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL no_done_after_abort got %0d pulses want 0", seen); end
        run_op(24'h800000, 24'hC00000, n);
        checks++;
        if ({n[7:0], bus.ans, bus.sticky} !== {8'd24, 24'h555555, 1'b1}) begin
            errors++;
            $display("FAIL post_reset got n=%0d ans=%h sticky=%b want 24 555555 1",
                     n, bus.ans, bus.sticky);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.Q = 24'h0;
        bus.M = 24'h0;
        #22;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_normal();
        test_special();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
